// File: rtl/instr_fetch.sv
// Instruction fetch: sequential word fetch from ROM-Flash into a
// prefetch FIFO, with redirect/flush and a sticky region fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0800_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] bus_address,
  output logic        bus_write_enable,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    FETCH,
    FAULT
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic in_region;
  logic has_room;
  logic issue;
  logic push;
  logic pop;

  assign in_region = (fetch_pc[31:20] == 12'h080);
  // Reserve a slot for the in-flight word so a capture never overflows.
  assign has_room  = (count + CW'(inflight)) < CW'(DEPTH);
  assign issue     = (state == FETCH) && !redirect
                   && in_region && has_room;
  assign push      = inflight && !redirect;
  assign pop       = instr_valid && instr_ready;

  assign bus_address      = fetch_pc;
  assign bus_write_enable = 1'b0;
  assign bus_data_out     = '0;

  assign instr_valid = (count != '0);
  assign instr_data  = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign fetch_fault = (state == FAULT);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Redirect always returns to FETCH; leaving the region faults.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else if (state == FETCH && !in_region) begin
      state_next = FAULT;
    end
  end

  // Fetch address and the single outstanding bus read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd1;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by count, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_ptr] <= bus_data_in;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random ready and
// redirect traffic checked against a stream-level reference model.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0800_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bus_address;
  logic        bus_write_enable;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  // Reference model: next pc decode must receive, edges since the
  // last flush, and the earliest edge count a fault may appear at.
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_fmin;

  logic [31:0] qpc[$];
  logic [31:0] qd[$];
  int          qi[$];

  instr_fetch dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .bus_address      (bus_address),
    .bus_write_enable (bus_write_enable),
    .bus_data_out     (bus_data_out),
    .bus_data_in      (bus_data_in),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .fetch_fault      (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a - 32'h0800_0000);
  endfunction

  function automatic logic in_reg(input logic [31:0] a);
    return (a >= 32'h0800_0000) && (a <= 32'h080F_FFFF);
  endfunction

  function automatic int fmin(input logic [31:0] t);
    if (in_reg(t)) return int'(32'h0810_0000 - t) + 1;
    return 1;
  endfunction

  // Synchronous-read ROM: address at edge N, data at edge N+1.
  always @(posedge clock) bus_data_in <= mem_word(bus_address);

  task automatic cycle(
    input  logic        rdy,
    input  logic        rdr,
    input  logic [31:0] rpc,
    output logic        popped,
    output logic [31:0] ppc,
    output logic [31:0] pdata
  );
    logic ev;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    popped = instr_valid && rdy;
    ppc    = instr_pc;
    pdata  = instr_data;
    @(posedge clock);
    @(negedge clock);
    redirect = 1'b0;
    if (popped) begin
      n_pops++;
      checks++;
      if (ppc !== m_pc || pdata !== mem_word(m_pc)) begin
        errors++;
        $display("FAIL pop: got pc=%h data=%h want pc=%h data=%h",
                 ppc, pdata, m_pc, mem_word(m_pc));
      end
      m_pc = m_pc + 32'd1;
    end
    if (rdr) begin
      m_pc   = rpc;
      m_cnt  = 0;
      m_fmin = fmin(rpc);
    end else begin
      m_cnt++;
    end
    ev = (m_cnt >= 2) && in_reg(m_pc);
    checks++;
    if (instr_valid !== ev) begin
      errors++;
      $display("FAIL valid: got %b want %b (pc %h cnt %0d)",
               instr_valid, ev, m_pc, m_cnt);
    end
    if (m_cnt < m_fmin) begin
      checks++;
      if (fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_early: got %b want 0", fetch_fault);
      end
    end else if (!in_reg(m_pc) && m_cnt >= 1) begin
      checks++;
      if (fetch_fault !== 1'b1) begin
        errors++;
        $display("FAIL fault_late: got %b want 1", fetch_fault);
      end
    end
    checks++;
    if (bus_write_enable !== 1'b0 || bus_data_out !== 32'h0) begin
      errors++;
      $display("FAIL bus_write: we=%b dout=%h want 0/0",
               bus_write_enable, bus_data_out);
    end
  endtask

  task automatic run(input int n, input logic rdy);
    logic        p;
    logic [31:0] pc;
    logic [31:0] d;
    qpc.delete();
    qd.delete();
    qi.delete();
    for (int i = 0; i < n; i++) begin
      cycle(rdy, 1'b0, 32'h0, p, pc, d);
      if (p) begin
        qpc.push_back(pc);
        qd.push_back(d);
        qi.push_back(i);
      end
    end
  endtask

  task automatic apply_reset(
    output logic        v,
    output logic        f,
    output logic [31:0] a
  );
    @(negedge clock);
    #2;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    #1;
    v = instr_valid;
    f = fetch_fault;
    a = bus_address;
    @(negedge clock);
    reset_n = 1'b1;
    m_pc    = RPC;
    m_cnt   = 0;
    m_fmin  = fmin(RPC);
  endtask

  task automatic test_reset();
    logic        v;
    logic        f;
    logic [31:0] a;
    apply_reset(v, f, a);
    checks++;
    if (v !== 1'b0 || f !== 1'b0 || a !== RPC) begin
      errors++;
      $display("FAIL reset_vals: v=%b f=%b a=%h want 0 0 %h",
               v, f, a, RPC);
    end
    checks++;
    if (bus_write_enable !== 1'b0 || bus_data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: we=%b dout=%h want 0/0",
               bus_write_enable, bus_data_out);
    end
    run(5, 1'b1);
    checks++;
    if (qpc.size() != 3) begin
      errors++;
      $display("FAIL first_count: got %0d want 3", qpc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (qi[k] != k + 2 || qpc[k] !== RPC + 32'(k)
            || qd[k] !== 32'hA0 + 32'(k)) begin
          errors++;
          $display("FAIL first_%0d: cyc=%0d pc=%h d=%h want %0d %h %h",
                   k, qi[k], qpc[k], qd[k], k + 2,
                   RPC + 32'(k), 32'hA0 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        v;
    logic        f;
    logic [31:0] a;
    logic [31:0] a6;
    apply_reset(v, f, a);
    run(6, 1'b0);
    a6 = bus_address;
    run(4, 1'b0);
    checks++;
    if (a6 !== RPC + 32'd4 || bus_address !== RPC + 32'd4) begin
      errors++;
      $display("FAIL stall_addr: got %h/%h want %h",
               a6, bus_address, RPC + 32'd4);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RPC) begin
      errors++;
      $display("FAIL stall_head: v=%b pc=%h want 1 %h",
               instr_valid, instr_pc, RPC);
    end
    run(8, 1'b1);
    checks++;
    if (qpc.size() != 8) begin
      errors++;
      $display("FAIL stall_drain: got %0d pops want 8", qpc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (qpc[k] !== RPC + 32'(k)) begin
          errors++;
          $display("FAIL stall_seq_%0d: got %h want %h",
                   k, qpc[k], RPC + 32'(k));
        end
      end
    end
  endtask

  task automatic test_redirect();
    logic        v;
    logic        f;
    logic [31:0] a;
    logic        p;
    logic [31:0] pc;
    logic [31:0] d;
    apply_reset(v, f, a);
    run(4, 1'b0);
    cycle(1'b0, 1'b1, 32'h0800_0100, p, pc, d);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%b want 0", instr_valid);
    end
    run(6, 1'b1);
    checks++;
    if (qpc.size() != 4) begin
      errors++;
      $display("FAIL redir_count: got %0d want 4", qpc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (qpc[k] !== 32'h0800_0100 + 32'(k)
            || qd[k] !== mem_word(32'h0800_0100 + 32'(k))) begin
          errors++;
          $display("FAIL redir_seq_%0d: got %h/%h want %h",
                   k, qpc[k], qd[k], 32'h0800_0100 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_fault_boundary();
    logic        p;
    logic [31:0] pc;
    logic [31:0] d;
    cycle(1'b1, 1'b1, 32'h080F_FFFE, p, pc, d);
    run(8, 1'b1);
    checks++;
    if (qpc.size() != 2 || qpc[0] !== 32'h080F_FFFE
        || qpc[1] !== 32'h080F_FFFF) begin
      errors++;
      $display("FAIL edge_words: got %0d pops want FFFE,FFFF",
               qpc.size());
    end
    checks++;
    if (fetch_fault !== 1'b1 || bus_address !== 32'h0810_0000) begin
      errors++;
      $display("FAIL edge_fault: f=%b a=%h want 1 08100000",
               fetch_fault, bus_address);
    end
    cycle(1'b1, 1'b1, RPC, p, pc, d);
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: got %b want 0", fetch_fault);
    end
    run(4, 1'b1);
    checks++;
    if (qpc.size() != 2 || qpc[0] !== RPC) begin
      errors++;
      $display("FAIL resume: got %0d pops want 2 from %h",
               qpc.size(), RPC);
    end
  endtask

  task automatic test_out_region();
    logic        p;
    logic [31:0] pc;
    logic [31:0] d;
    int          nv;
    cycle(1'b1, 1'b1, 32'h0, p, pc, d);
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL oor_r0: fault=%b want 0", fetch_fault);
    end
    cycle(1'b1, 1'b0, 32'h0, p, pc, d);
    checks++;
    if (fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL oor_r1: fault=%b want 1", fetch_fault);
    end
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0, p, pc, d);
      if (instr_valid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL oor_valid: got %0d valid cycles want 0", nv);
    end
    cycle(1'b0, 1'b1, 32'h0800_0040, p, pc, d);
    run(6, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0800_0040
        || bus_address !== 32'h0800_0044) begin
      errors++;
      $display("FAIL full: v=%b pc=%h a=%h want 1 08000040 08000044",
               instr_valid, instr_pc, bus_address);
    end
    cycle(1'b1, 1'b1, 32'h0800_0080, p, pc, d);
    checks++;
    if (p !== 1'b1 || pc !== 32'h0800_0040 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_flush: p=%b pc=%h v=%b want 1 08000040 0",
               p, pc, instr_valid);
    end
    run(4, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic        v;
    logic        f;
    logic [31:0] a;
    apply_reset(v, f, a);
    run(3, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || bus_address !== RPC + 32'd3) begin
      errors++;
      $display("FAIL pre_mid: v=%b a=%h want 1 %h",
               instr_valid, bus_address, RPC + 32'd3);
    end
    apply_reset(v, f, a);
    checks++;
    if (v !== 1'b0 || f !== 1'b0 || a !== RPC) begin
      errors++;
      $display("FAIL mid_reset: v=%b f=%b a=%h want 0 0 %h",
               v, f, a, RPC);
    end
    run(4, 1'b1);
    checks++;
    if (qpc.size() != 2 || qpc[0] !== RPC || qd[0] !== 32'hA0) begin
      errors++;
      $display("FAIL mid_restart: got %0d pops want 2 from %h",
               qpc.size(), RPC);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        f;
    logic [31:0] a;
    logic        p;
    logic [31:0] pc;
    logic [31:0] d;
    logic        rdy;
    logic        rdr;
    logic [31:0] t;
    int          base;
    apply_reset(v, f, a);
    base = n_pops;
    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       t = RPC + 32'($urandom_range(0, 4095));
        1:       t = 32'h080F_FFF8 + 32'($urandom_range(0, 7));
        default: t = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
      endcase
      cycle(rdy, rdr, t, p, pc, d);
    end
    checks++;
    if (n_pops - base < 200) begin
      errors++;
      $display("FAIL rand_progress: got %0d pops want >=200",
               n_pops - base);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_fault_boundary();
    test_out_region();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
